// File: rtl/axi_cache_pkg.sv
// Shared types and constants for the AXI write-path blocks.
// Burst/response encodings, arbiter FSM states, AXI length width.
package axi_cache_pkg;

    localparam int AXI_LEN_W = 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        AW   = 2'b01,
        W    = 2'b10
    } wr_arb_state_e;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way grant select; round-robin pointer when WR_ARB_RR_EN is
// defined, otherwise fixed priority with requester 0 winning.
module axi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       served_i,
    output logic       gnt_o
);

`ifdef WR_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) ptr_d = ~served_i;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

    assign gnt_o = (&req_i) ? ptr_q : req_i[1];
`else
    logic unused;
    assign unused = ^{clk, rst, upd_i, served_i};
    assign gnt_o  = ~req_i[0] & req_i[1];
`endif

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI4 write arbiter with ID tagging, B routing and
// outstanding bound. WR_ARB_RR_EN selects round-robin arbitration.
module axi_wr_arbiter
    import axi_cache_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s0_awvalid,
    output logic                          s0_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s0_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]       s0_awid,
    input  logic [AXI_LEN_W-1:0]          s0_awlen,
    input  logic [2:0]                    s0_awsize,
    input  logic [1:0]                    s0_awburst,
    input  logic                          s0_wvalid,
    output logic                          s0_wready,
    input  logic [AXI_DATA_WIDTH-1:0]     s0_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s0_wstrb,
    input  logic                          s0_wlast,
    output logic                          s0_bvalid,
    input  logic                          s0_bready,
    output logic [1:0]                    s0_bresp,
    output logic [AXI_ID_WIDTH-1:0]       s0_bid,
    input  logic                          s1_awvalid,
    output logic                          s1_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s1_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]       s1_awid,
    input  logic [AXI_LEN_W-1:0]          s1_awlen,
    input  logic [2:0]                    s1_awsize,
    input  logic [1:0]                    s1_awburst,
    input  logic                          s1_wvalid,
    output logic                          s1_wready,
    input  logic [AXI_DATA_WIDTH-1:0]     s1_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s1_wstrb,
    input  logic                          s1_wlast,
    output logic                          s1_bvalid,
    input  logic                          s1_bready,
    output logic [1:0]                    s1_bresp,
    output logic [AXI_ID_WIDTH-1:0]       s1_bid,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_awaddr,
    output logic [AXI_ID_WIDTH:0]         m_awid,
    output logic [AXI_LEN_W-1:0]          m_awlen,
    output logic [2:0]                    m_awsize,
    output logic [1:0]                    m_awburst,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    output logic [AXI_DATA_WIDTH-1:0]     m_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                          m_wlast,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    input  logic [1:0]                    m_bresp,
    input  logic [AXI_ID_WIDTH:0]         m_bid,
    output logic                          wlast_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    wr_arb_state_e        state_q, state_d;
    logic                 g_q, g_d;
    logic [AXI_LEN_W-1:0] len_q, len_d;
    logic [AXI_LEN_W-1:0] beat_q, beat_d;
    logic [CW-1:0]        outst_q, outst_d;
    logic                 err_q, err_d;
    logic                 arb_g, arb_upd;
    logic                 sg_awvalid, sg_wvalid, sg_wlast;
    logic                 aw_hs, b_hs, bsel;

    axi_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({s1_awvalid, s0_awvalid}),
        .upd_i    (arb_upd),
        .served_i (g_q),
        .gnt_o    (arb_g)
    );

    assign sg_awvalid = g_q ? s1_awvalid : s0_awvalid;
    assign sg_wvalid  = g_q ? s1_wvalid  : s0_wvalid;
    assign sg_wlast   = g_q ? s1_wlast   : s0_wlast;

    assign m_awaddr  = g_q ? s1_awaddr  : s0_awaddr;
    assign m_awid    = {g_q, g_q ? s1_awid : s0_awid};
    assign m_awlen   = g_q ? s1_awlen   : s0_awlen;
    assign m_awsize  = g_q ? s1_awsize  : s0_awsize;
    assign m_awburst = g_q ? s1_awburst : s0_awburst;
    assign m_wdata   = g_q ? s1_wdata   : s0_wdata;
    assign m_wstrb   = g_q ? s1_wstrb   : s0_wstrb;
    assign wlast_err = err_q;

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        len_d      = len_q;
        beat_d     = beat_q;
        err_d      = err_q;
        arb_upd    = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_wlast    = 1'b0;
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((s0_awvalid || s1_awvalid) && outst_q < MAX_C) begin
                    g_d     = arb_g;
                    len_d   = arb_g ? s1_awlen : s0_awlen;
                    state_d = AW;
                end
            end
            AW: begin
                m_awvalid  = sg_awvalid;
                s0_awready = ~g_q & m_awready;
                s1_awready =  g_q & m_awready;
                if (m_awvalid && m_awready) begin
                    beat_d  = '0;
                    state_d = W;
                end
            end
            W: begin
                m_wvalid  = sg_wvalid;
                m_wlast   = (beat_q == len_q);
                s0_wready = ~g_q & m_wready;
                s1_wready =  g_q & m_wready;
                if (m_wvalid && m_wready) begin
                    beat_d = beat_q + 1'b1;
                    if (sg_wlast != m_wlast) err_d = 1'b1;
                    if (m_wlast) begin
                        state_d = IDLE;
                        arb_upd = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // B routing is purely combinational on the requester tag bit
    assign bsel      = m_bid[AXI_ID_WIDTH];
    assign s0_bvalid = m_bvalid & ~bsel;
    assign s1_bvalid = m_bvalid &  bsel;
    assign m_bready  = bsel ? s1_bready : s0_bready;
    assign s0_bid    = m_bid[AXI_ID_WIDTH-1:0];
    assign s1_bid    = m_bid[AXI_ID_WIDTH-1:0];
    assign s0_bresp  = m_bresp;
    assign s1_bresp  = m_bresp;

    assign aw_hs = m_awvalid & m_awready;
    assign b_hs  = m_bvalid & m_bready;

    always_comb begin
        outst_d = outst_q;
        if (aw_hs && !b_hs)
            outst_d = outst_q + 1'b1;
        else if (!aw_hs && b_hs && outst_q != '0)
            outst_d = outst_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            outst_q <= outst_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: arbitration, outstanding limit,
// B routing, WLAST regeneration and reset; honours WR_ARB_RR_EN.
module tb_axi_wr_arbiter;
    import axi_cache_pkg::*;

    localparam int A = 32;
    localparam int D = 64;
    localparam int S = 8;
    localparam int I = 4;

    typedef logic [I+A+13:0] aw_t;
    typedef logic [D+S:0]    w_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic s0_awvalid, s0_awready, s1_awvalid, s1_awready;
    logic [A-1:0] s0_awaddr, s1_awaddr, m_awaddr;
    logic [I-1:0] s0_awid, s1_awid, s0_bid, s1_bid;
    logic [7:0] s0_awlen, s1_awlen, m_awlen;
    logic [2:0] s0_awsize, s1_awsize, m_awsize;
    logic [1:0] s0_awburst, s1_awburst, m_awburst;
    logic s0_wvalid, s0_wready, s0_wlast, s1_wvalid, s1_wready, s1_wlast;
    logic [D-1:0] s0_wdata, s1_wdata, m_wdata;
    logic [S-1:0] s0_wstrb, s1_wstrb, m_wstrb;
    logic s0_bvalid, s0_bready, s1_bvalid, s1_bready;
    logic [1:0] s0_bresp, s1_bresp, m_bresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic m_bvalid, m_bready, wlast_err;
    logic [I:0] m_awid, m_bid;

    int total = 0;
    int bad = 0;
    aw_t exp_aw[$], obs_aw[$];
    w_t  exp_w[$], obs_w[$];
    aw_t ea, oa;
    w_t  ew, ow;

    axi_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_awaddr(s0_awaddr), .s0_awid(s0_awid), .s0_awlen(s0_awlen),
        .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
        .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata),
        .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s0_bresp(s0_bresp), .s0_bid(s0_bid),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_awaddr(s1_awaddr), .s1_awid(s1_awid), .s1_awlen(s1_awlen),
        .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata),
        .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s1_bresp(s1_bresp), .s1_bid(s1_bid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_bid(m_bid), .wlast_err(wlast_err)
    );

    always @(posedge clk) begin
        if (!rst && m_awvalid && m_awready)
            obs_aw.push_back({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst});
        if (!rst && m_wvalid && m_wready)
            obs_w.push_back({m_wdata, m_wstrb, m_wlast});
    end

    function automatic logic [D-1:0] dat(int s, logic [A-1:0] a, int b);
        return {a, 16'(s), 16'(b)};
    endfunction

    function automatic void push_exp(int s, logic [I-1:0] id, logic [A-1:0] a, int len);
        logic [2:0] sz;
        logic [S-1:0] sb;
        sz = (s != 0) ? 3'd2 : 3'd3;
        sb = (s != 0) ? 8'h0F : 8'hFF;
        exp_aw.push_back({s[0], id, a, 8'(len), sz, BURST_INCR});
        for (int b = 0; b <= len; b++)
            exp_w.push_back({dat(s, a, b), sb, (b == len)});
    endfunction

    task automatic inputs_idle();
        s0_awvalid = 0; s0_awaddr = '0; s0_awid = '0; s0_awlen = '0;
        s0_awsize = '0; s0_awburst = '0; s0_wvalid = 0; s0_wdata = '0;
        s0_wstrb = '0; s0_wlast = 0; s0_bready = 0;
        s1_awvalid = 0; s1_awaddr = '0; s1_awid = '0; s1_awlen = '0;
        s1_awsize = '0; s1_awburst = '0; s1_wvalid = 0; s1_wdata = '0;
        s1_wstrb = '0; s1_wlast = 0; s1_bready = 0;
        m_awready = 1; m_wready = 1; m_bvalid = 0; m_bresp = '0; m_bid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        inputs_idle();
        repeat (2) @(negedge clk);
        rst = 0;
        exp_aw.delete(); obs_aw.delete(); exp_w.delete(); obs_w.delete();
    endtask

    // Returns just after the posedge of the last W handshake, W still driven
    task automatic send(input int s, input logic [I-1:0] id,
                        input logic [A-1:0] a, input int len, input int bad_b);
        logic r;
        int n;
        @(negedge clk);
        if (s == 0) begin
            s0_wvalid = 0; s0_awvalid = 1; s0_awid = id; s0_awaddr = a;
            s0_awlen = 8'(len); s0_awsize = 3'd3; s0_awburst = BURST_INCR;
        end else begin
            s1_wvalid = 0; s1_awvalid = 1; s1_awid = id; s1_awaddr = a;
            s1_awlen = 8'(len); s1_awsize = 3'd2; s1_awburst = BURST_INCR;
        end
        n = 0;
        forever begin
            #1 r = (s != 0) ? s1_awready : s0_awready;
            @(posedge clk);
            n++;
            if (r || n > 200) break;
            @(negedge clk);
        end
        total++;
        if (!r) begin
            bad++;
            $display("FAIL aw_timeout s%0d got=no_handshake want=handshake", s);
            return;
        end
        for (int b = 0; b <= len; b++) begin
            @(negedge clk);
            if (s == 0) begin
                s0_awvalid = 0; s0_wvalid = 1; s0_wdata = dat(s, a, b);
                s0_wstrb = 8'hFF; s0_wlast = (b == len) || (b == bad_b);
            end else begin
                s1_awvalid = 0; s1_wvalid = 1; s1_wdata = dat(s, a, b);
                s1_wstrb = 8'h0F; s1_wlast = (b == len) || (b == bad_b);
            end
            n = 0;
            forever begin
                #1 r = (s != 0) ? s1_wready : s0_wready;
                @(posedge clk);
                n++;
                if (r || n > 200) break;
                @(negedge clk);
            end
            if (!r) begin
                total++; bad++;
                $display("FAIL w_timeout s%0d beat=%0d got=no_handshake want=handshake", s, b);
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        inputs_idle();
        s0_awvalid = 1; s1_awvalid = 1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({m_awvalid, m_wvalid, m_wlast, s0_bvalid, s1_bvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_valids got=%b want=00000",
                     {m_awvalid, m_wvalid, m_wlast, s0_bvalid, s1_bvalid});
        end
        total++;
        if ({s0_awready, s1_awready, s0_wready, s1_wready, m_bready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_readys got=%b want=00000",
                     {s0_awready, s1_awready, s0_wready, s1_wready, m_bready});
        end
        total++;
        if (wlast_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_wlast_err got=%b want=0", wlast_err);
        end
        s0_awvalid = 0; s1_awvalid = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single();
        do_reset();
        push_exp(0, 4'hA, 32'h0000_1000, 3);
        send(0, 4'hA, 32'h0000_1000, 3, -1);
        @(negedge clk);
        s0_wvalid = 0;
        #1;
        total++;
        if ({m_awvalid, m_wvalid, s0_awready} !== 3'b000) begin
            bad++;
            $display("FAIL single_idle got=%b want=000", {m_awvalid, m_wvalid, s0_awready});
        end
        total++;
        if (obs_aw.size() != exp_aw.size() || obs_w.size() != exp_w.size()) begin
            bad++;
            $display("FAIL single_count aw=%0d/%0d w=%0d/%0d",
                     obs_aw.size(), exp_aw.size(), obs_w.size(), exp_w.size());
        end
        while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
            total++; ea = exp_aw.pop_front(); oa = obs_aw.pop_front();
            if (oa !== ea) begin bad++; $display("FAIL single_aw got=%h want=%h", oa, ea); end
        end
        while (exp_w.size() > 0 && obs_w.size() > 0) begin
            total++; ew = exp_w.pop_front(); ow = obs_w.pop_front();
            if (ow !== ew) begin bad++; $display("FAIL single_w got=%h want=%h", ow, ew); end
        end
        m_bvalid = 1; m_bid = 5'b0_1010; m_bresp = RESP_OKAY; s0_bready = 1;
        #1;
        total++;
        if ({s0_bvalid, s1_bvalid, m_bready, s0_bid, s0_bresp} !== {3'b101, 4'hA, 2'b00}) begin
            bad++;
            $display("FAIL b_route_s0 got=%b want=%b",
                     {s0_bvalid, s1_bvalid, m_bready, s0_bid, s0_bresp}, {3'b101, 4'hA, 2'b00});
        end
        @(negedge clk);
        m_bvalid = 0; s0_bready = 0;
    endtask

    task automatic test_arb();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 4'h1, 32'h2000 + 32'(r * 256), 1);
            push_exp(1, 4'h2, 32'h3000 + 32'(r * 256), 2);
            fork
                send(0, 4'h1, 32'h2000 + 32'(r * 256), 1, -1);
                send(1, 4'h2, 32'h3000 + 32'(r * 256), 2, -1);
            join
        end
        do_reset();
`ifdef WR_ARB_RR_EN
        push_exp(0, 4'h3, 32'h6000, 0);
        push_exp(1, 4'h4, 32'h7000, 0);
        push_exp(0, 4'h5, 32'h6100, 0);
`else
        push_exp(0, 4'h3, 32'h6000, 0);
        push_exp(0, 4'h5, 32'h6100, 0);
        push_exp(1, 4'h4, 32'h7000, 0);
`endif
        fork
            begin
                send(0, 4'h3, 32'h6000, 0, -1);
                send(0, 4'h5, 32'h6100, 0, -1);
            end
            send(1, 4'h4, 32'h7000, 0, -1);
        join
        @(negedge clk);
        total++;
        if (obs_aw.size() != exp_aw.size() || obs_w.size() != exp_w.size()) begin
            bad++;
            $display("FAIL arb_count aw=%0d/%0d w=%0d/%0d",
                     obs_aw.size(), exp_aw.size(), obs_w.size(), exp_w.size());
        end
        while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
            total++; ea = exp_aw.pop_front(); oa = obs_aw.pop_front();
            if (oa !== ea) begin bad++; $display("FAIL arb_aw got=%h want=%h", oa, ea); end
        end
        while (exp_w.size() > 0 && obs_w.size() > 0) begin
            total++; ew = exp_w.pop_front(); ow = obs_w.pop_front();
            if (ow !== ew) begin bad++; $display("FAIL arb_w got=%h want=%h", ow, ew); end
        end
    endtask

    task automatic test_outstanding();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_exp(0, 4'(k), 32'h5000 + 32'(k * 16), 0);
            send(0, 4'(k), 32'h5000 + 32'(k * 16), 0, -1);
        end
        @(negedge clk);
        s0_wvalid = 0; s0_awvalid = 1; s0_awid = 4'h9; s0_awaddr = 32'h5400;
        s0_awlen = 0; s0_awsize = 3'd3; s0_awburst = BURST_INCR;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            total++;
            if ({s0_awready, m_awvalid} !== 2'b00) begin
                bad++;
                $display("FAIL outst_hold cyc=%0d got=%b want=00", k, {s0_awready, m_awvalid});
            end
        end
        m_bvalid = 1; m_bid = 5'b0_0000; s0_bready = 1;
        @(negedge clk);
        m_bvalid = 0; s0_bready = 0;
        #1;
        total++;
        if (s0_awready !== 1'b0) begin
            bad++;
            $display("FAIL outst_idle_after_b got=%b want=0", s0_awready);
        end
        @(negedge clk);
        #1;
        total++;
        if ({s0_awready, m_awvalid} !== 2'b11) begin
            bad++;
            $display("FAIL outst_regrant got=%b want=11", {s0_awready, m_awvalid});
        end
        push_exp(0, 4'h9, 32'h5400, 0);
        @(negedge clk);
        s0_awvalid = 0; s0_wvalid = 1; s0_wdata = dat(0, 32'h5400, 0);
        s0_wstrb = 8'hFF; s0_wlast = 1;
        @(negedge clk);
        s0_wvalid = 0;
        @(negedge clk);
        total++;
        if (obs_aw.size() != exp_aw.size() || obs_w.size() != exp_w.size()) begin
            bad++;
            $display("FAIL outst_count aw=%0d/%0d w=%0d/%0d",
                     obs_aw.size(), exp_aw.size(), obs_w.size(), exp_w.size());
        end
        while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
            total++; ea = exp_aw.pop_front(); oa = obs_aw.pop_front();
            if (oa !== ea) begin bad++; $display("FAIL outst_aw got=%h want=%h", oa, ea); end
        end
        while (exp_w.size() > 0 && obs_w.size() > 0) begin
            total++; ew = exp_w.pop_front(); ow = obs_w.pop_front();
            if (ow !== ew) begin bad++; $display("FAIL outst_w got=%h want=%h", ow, ew); end
        end
    endtask

    task automatic test_simul_aw_b();
        int n;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push_exp(0, 4'(k), 32'h8000 + 32'(k * 16), 0);
            send(0, 4'(k), 32'h8000 + 32'(k * 16), 0, -1);
        end
        @(negedge clk);
        m_awready = 0;
        push_exp(0, 4'h2, 32'h8020, 0);
        fork
            send(0, 4'h2, 32'h8020, 0, -1);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    #2;
                    n++;
                end while (!m_awvalid && n < 50);
                @(negedge clk);
                m_awready = 1; m_bvalid = 1; m_bid = 5'b0_0000; s0_bready = 1;
                #1;
                total++;
                if ({m_awvalid, m_awready, m_bvalid, m_bready} !== 4'b1111) begin
                    bad++;
                    $display("FAIL simul_both_hs got=%b want=1111",
                             {m_awvalid, m_awready, m_bvalid, m_bready});
                end
                @(negedge clk);
                m_bvalid = 0; s0_bready = 0;
            end
        join
        for (int k = 3; k < 5; k++) begin
            push_exp(0, 4'(k), 32'h8000 + 32'(k * 16), 0);
            send(0, 4'(k), 32'h8000 + 32'(k * 16), 0, -1);
        end
        @(negedge clk);
        s0_wvalid = 0; s0_awvalid = 1; s0_awid = 4'hF; s0_awaddr = 32'h8F00;
        s0_awlen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            total++;
            if (s0_awready !== 1'b0) begin
                bad++;
                $display("FAIL simul_cnt_full cyc=%0d got=%b want=0", k, s0_awready);
            end
        end
        total++;
        if (obs_aw.size() != exp_aw.size() || obs_w.size() != exp_w.size()) begin
            bad++;
            $display("FAIL simul_count aw=%0d/%0d w=%0d/%0d",
                     obs_aw.size(), exp_aw.size(), obs_w.size(), exp_w.size());
        end
        while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
            total++; ea = exp_aw.pop_front(); oa = obs_aw.pop_front();
            if (oa !== ea) begin bad++; $display("FAIL simul_aw got=%h want=%h", oa, ea); end
        end
        while (exp_w.size() > 0 && obs_w.size() > 0) begin
            total++; ew = exp_w.pop_front(); ow = obs_w.pop_front();
            if (ow !== ew) begin bad++; $display("FAIL simul_w got=%h want=%h", ow, ew); end
        end
    endtask

    task automatic test_bresp_route();
        do_reset();
        m_bvalid = 1; m_bid = 5'b1_0101; m_bresp = RESP_SLVERR; s1_bready = 1;
        #1;
        total++;
        if ({s1_bvalid, s1_bid, s1_bresp, s0_bvalid, m_bready} !== {1'b1, 4'b0101, 2'b10, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL b_route_s1 got=%b want=%b",
                     {s1_bvalid, s1_bid, s1_bresp, s0_bvalid, m_bready},
                     {1'b1, 4'b0101, 2'b10, 1'b0, 1'b1});
        end
        s1_bready = 0; s0_bready = 1;
        #1;
        total++;
        if (m_bready !== 1'b0) begin
            bad++;
            $display("FAIL b_ready_select got=%b want=0", m_bready);
        end
        @(negedge clk);
        m_bvalid = 0; s0_bready = 0;
    endtask

    task automatic test_wlast_rst();
        do_reset();
        total++;
        if (wlast_err !== 1'b0) begin
            bad++;
            $display("FAIL err_before got=%b want=0", wlast_err);
        end
        push_exp(1, 4'h6, 32'h9000, 1);
        send(1, 4'h6, 32'h9000, 1, 0);
        @(negedge clk);
        s1_wvalid = 0;
        #1;
        total++;
        if (wlast_err !== 1'b1) begin
            bad++;
            $display("FAIL err_set got=%b want=1", wlast_err);
        end
        total++;
        if (obs_aw.size() != exp_aw.size() || obs_w.size() != exp_w.size()) begin
            bad++;
            $display("FAIL wlast_count aw=%0d/%0d w=%0d/%0d",
                     obs_aw.size(), exp_aw.size(), obs_w.size(), exp_w.size());
        end
        while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
            total++; ea = exp_aw.pop_front(); oa = obs_aw.pop_front();
            if (oa !== ea) begin bad++; $display("FAIL wlast_aw got=%h want=%h", oa, ea); end
        end
        while (exp_w.size() > 0 && obs_w.size() > 0) begin
            total++; ew = exp_w.pop_front(); ow = obs_w.pop_front();
            if (ow !== ew) begin bad++; $display("FAIL wlast_w got=%h want=%h", ow, ew); end
        end
        @(negedge clk);
        s0_awvalid = 1; s0_awid = 4'h7; s0_awaddr = 32'hA000; s0_awlen = 8'd3;
        s0_awsize = 3'd3; s0_awburst = BURST_INCR;
        @(negedge clk);
        #1;
        total++;
        if ({s0_awready, m_awvalid, m_awid} !== {2'b11, 5'b0_0111}) begin
            bad++;
            $display("FAIL aw_latency got=%b want=%b", {s0_awready, m_awvalid, m_awid}, {2'b11, 5'b0_0111});
        end
        @(negedge clk);
        s0_awvalid = 0; s0_wvalid = 1; s0_wdata = dat(0, 32'hA000, 0);
        s0_wstrb = 8'hFF; s0_wlast = 0;
        @(negedge clk);
        #1;
        total++;
        if ({m_wvalid, m_wlast} !== 2'b10) begin
            bad++;
            $display("FAIL mid_burst got=%b want=10", {m_wvalid, m_wlast});
        end
        rst = 1;
        @(negedge clk);
        #1;
        total++;
        if ({m_awvalid, m_wvalid, m_wlast, s0_awready, s0_wready, s1_wready, wlast_err} !== 7'b0) begin
            bad++;
            $display("FAIL rst_in_w got=%b want=0000000",
                     {m_awvalid, m_wvalid, m_wlast, s0_awready, s0_wready, s1_wready, wlast_err});
        end
        inputs_idle();
        @(negedge clk);
        rst = 0;
        exp_aw.delete(); obs_aw.delete(); exp_w.delete(); obs_w.delete();
        push_exp(1, 4'h8, 32'hB000, 0);
        send(1, 4'h8, 32'hB000, 0, -1);
        @(negedge clk);
        s1_wvalid = 0;
        total++;
        if (obs_aw.size() != exp_aw.size() || obs_w.size() != exp_w.size()) begin
            bad++;
            $display("FAIL recover_count aw=%0d/%0d w=%0d/%0d",
                     obs_aw.size(), exp_aw.size(), obs_w.size(), exp_w.size());
        end
        while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
            total++; ea = exp_aw.pop_front(); oa = obs_aw.pop_front();
            if (oa !== ea) begin bad++; $display("FAIL recover_aw got=%h want=%h", oa, ea); end
        end
        while (exp_w.size() > 0 && obs_w.size() > 0) begin
            total++; ew = exp_w.pop_front(); ow = obs_w.pop_front();
            if (ow !== ew) begin bad++; $display("FAIL recover_w got=%h want=%h", ow, ew); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arb();
        test_outstanding();
        test_simul_aw_b();
        test_bresp_route();
        test_wlast_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
